// File: rtl/alp_seq_pkg.sv
// Shared definitions for the ALP D/Q controllers: sequencer states and
// the D/Q control field encodings driven into the ALP D/Q decode.
package alp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } alp_state_e;

    // D/Q field encodings
    localparam logic [1:0] DQ_HOLD  = 2'b00;  // Q write disabled
    localparam logic [1:0] DQ_LOAD  = 2'b10;  // Q loads from the A mux
    localparam logic [1:0] DQ_SHR   = 2'b11;  // Q shift right (multiply)
    localparam logic [1:0] DQ_SHL   = 2'b10;  // Q shift left (divide)
    localparam logic [1:0] DQ_FIXUP = 2'b11;

    // MUX field encodings; step encodings carry the add/sub decision in bit 3
    localparam logic [3:0] MUX_HOLD    = 4'b0100;
    localparam logic [3:0] MUX_LOAD    = 4'b0000;
    localparam logic [2:0] MUX_MUL_LOW = 3'b001;
    localparam logic [2:0] MUX_DIV_LOW = 3'b011;
    localparam logic [3:0] MUX_FIXUP   = 4'b1001;

    typedef struct packed {
        logic       dmove;
        logic       dreg_inh_l;
        logic [1:0] dq;
        logic [3:0] mux;
    } dq_ctl_t;

    // Parked encoding: D inhibited, Q not written, datapath holds.
    function automatic dq_ctl_t hold_ctl();
        dq_ctl_t c;
        c.dmove      = 1'b0;
        c.dreg_inh_l = 1'b0;
        c.dq         = DQ_HOLD;
        c.mux        = MUX_HOLD;
        return c;
    endfunction

endpackage

// File: rtl/alp_step_ctr.sv
// Loadable step counter with terminal-count flag at STEPS-1.
module alp_step_ctr #(
    parameter int STEPS = 32,
    parameter int CW    = 6
) (
    input  logic          clk_h,
    input  logic          reset_h,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    // Clear has priority over counting.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/alp_mdseq.sv
// Multiply/divide step sequencer: drives ALP D/Q controls through
// LOAD, STEPS shift/add steps and an optional divide fixup.
//
// Handshake: start_h is a level request sampled only in IDLE (one
// acceptance per IDLE cycle, no ready needed); done_h is a one-cycle
// completion pulse, never asserted for an aborted or reset operation.
module alp_mdseq
    import alp_seq_pkg::*;
#(
    parameter int STEPS = 32,
    parameter int CW    = 6
) (
    input  logic          clk_h,
    input  logic          reset_h,
    input  logic          start_h,
    input  logic          op_div_h,
    input  logic          dvz_in_h,
    input  logic          abort_h,
    input  logic          q0_h,
    input  logic          sign_h,
    output logic          dmove_h,
    output logic          dreg_inh_l,
    output logic [1:0]    dq_h,
    output logic [3:0]    mux_h,
    output logic          busy_h,
    output logic          done_h,
    output logic          dvz_h,
    output logic [CW-1:0] step_h,
    output alp_state_e    state_dbg
);

    alp_state_e    state, state_nx;
    logic          op_div_q;
    logic [CW-1:0] count;
    logic          last_step;
    dq_ctl_t       ctl;

    alp_step_ctr #(.STEPS(STEPS), .CW(CW)) u_ctr (
        .clk_h   (clk_h),
        .reset_h (reset_h),
        .clr     (state == S_LOAD),
        .en      (state == S_STEP),
        .count   (count),
        .tc      (last_step)
    );

    // State register.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Operation type and divide-by-zero flag are captured on an accepted start.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            op_div_q <= 1'b0;
            dvz_h    <= 1'b0;
        end else if (state == S_IDLE && start_h) begin
            op_div_q <= op_div_h;
            dvz_h    <= op_div_h & dvz_in_h;
        end
    end

    // Next-state logic; abort only acts while busy, start only in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_h) state_nx = (op_div_h && dvz_in_h) ? S_DONE : S_LOAD;
            S_LOAD:  state_nx = abort_h ? S_IDLE : S_STEP;
            S_STEP: begin
                if (abort_h)
                    state_nx = S_IDLE;
                else if (last_step)
                    state_nx = op_div_q ? S_FIXUP : S_DONE;
            end
            S_FIXUP: state_nx = abort_h ? S_IDLE : S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from state plus the registered datapath status bits.
    always_comb begin
        ctl    = hold_ctl();
        busy_h = 1'b0;
        done_h = 1'b0;
        step_h = '0;
        case (state)
            S_LOAD: begin
                busy_h         = 1'b1;
                ctl.dmove      = 1'b1;
                ctl.dreg_inh_l = 1'b1;
                ctl.dq         = DQ_LOAD;
                ctl.mux        = MUX_LOAD;
            end
            S_STEP: begin
                busy_h         = 1'b1;
                step_h         = count;
                ctl.dreg_inh_l = 1'b1;
                if (op_div_q) begin
                    ctl.dq  = DQ_SHL;
                    ctl.mux = {~sign_h, MUX_DIV_LOW};
                end else begin
                    ctl.dq  = DQ_SHR;
                    ctl.mux = {q0_h, MUX_MUL_LOW};
                end
            end
            S_FIXUP: begin
                busy_h = 1'b1;
                if (sign_h) begin
                    ctl.dreg_inh_l = 1'b1;
                    ctl.dq         = DQ_FIXUP;
                    ctl.mux        = MUX_FIXUP;
                end
            end
            S_DONE:  done_h = 1'b1;
            default: ;
        endcase
    end

    assign dmove_h    = ctl.dmove;
    assign dreg_inh_l = ctl.dreg_inh_l;
    assign dq_h       = ctl.dq;
    assign mux_h      = ctl.mux;
    assign state_dbg  = state;

endmodule

// File: tb/tb_alp_mdseq.sv
// Bench for alp_mdseq: timeline model of each operation (cycle number
// since acceptance) checked every cycle, plus directed literal checks.
module tb_alp_mdseq;
    import alp_seq_pkg::*;

    localparam int STEPS = 32;
    localparam int CW    = 6;

    logic          clk_h = 1'b0;
    logic          reset_h = 1'b1;
    logic          start_h = 1'b0, op_div_h = 1'b0, dvz_in_h = 1'b0, abort_h = 1'b0;
    logic          q0_h = 1'b0, sign_h = 1'b0;
    logic          dmove_h, dreg_inh_l, busy_h, done_h, dvz_h;
    logic [1:0]    dq_h;
    logic [3:0]    mux_h;
    logic [CW-1:0] step_h;
    alp_state_e    state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    bit q0_alt   = 1'b0;
    bit sign_alt = 1'b0;

    // ---------------- clock/reset ----------------
    always #5 clk_h = ~clk_h;

    alp_mdseq #(.STEPS(STEPS), .CW(CW)) dut (
        .clk_h(clk_h), .reset_h(reset_h), .start_h(start_h), .op_div_h(op_div_h),
        .dvz_in_h(dvz_in_h), .abort_h(abort_h), .q0_h(q0_h), .sign_h(sign_h),
        .dmove_h(dmove_h), .dreg_inh_l(dreg_inh_l), .dq_h(dq_h), .mux_h(mux_h),
        .busy_h(busy_h), .done_h(done_h), .dvz_h(dvz_h), .step_h(step_h),
        .state_dbg(state_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // k = cycles since the accepting edge (-1 when idle).
    int k = -1;
    bit m_div = 1'b0, m_dz = 1'b0, m_dvz = 1'b0;

    function automatic int m_last();
        if (m_dz) return 1;
        return m_div ? STEPS + 3 : STEPS + 2;
    endfunction

    always @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            k = -1;
            m_dvz = 1'b0;
        end else if (k < 0) begin
            if (start_h) begin
                k = 1;
                m_div = op_div_h;
                m_dz = op_div_h & dvz_in_h;
                m_dvz = m_dz;
            end
        end else if (k == m_last()) begin
            k = -1;
        end else if (abort_h) begin
            k = -1;
        end else begin
            k++;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk_h) begin
        int e_dmove, e_inh, e_dq, e_mux, e_busy, e_done, e_step;
        e_dmove = 0; e_inh = 0; e_dq = 0; e_mux = 4; e_busy = 0; e_done = 0; e_step = 0;
        if (k >= 1) begin
            if (m_dz) begin
                e_done = 1;
            end else if (k == 1) begin
                e_dmove = 1; e_inh = 1; e_dq = 2; e_mux = 0; e_busy = 1;
            end else if (k <= STEPS + 1) begin
                e_busy = 1; e_inh = 1; e_step = k - 2;
                if (m_div) begin
                    e_dq = 2; e_mux = sign_h ? 3 : 11;
                end else begin
                    e_dq = 3; e_mux = q0_h ? 9 : 1;
                end
            end else if (m_div && k == STEPS + 2) begin
                e_busy = 1;
                if (sign_h) begin
                    e_inh = 1; e_dq = 3; e_mux = 9;
                end
            end else begin
                e_done = 1;
            end
        end
        check("dmove_h", int'(dmove_h), e_dmove);
        check("dreg_inh_l", int'(dreg_inh_l), e_inh);
        check("dq_h", int'(dq_h), e_dq);
        check("mux_h", int'(mux_h), e_mux);
        check("busy_h", int'(busy_h), e_busy);
        check("done_h", int'(done_h), e_done);
        check("dvz_h", int'(dvz_h), int'(m_dvz));
        check("step_h", int'(step_h), e_step);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_h);
        #1;
        if (q0_alt) q0_h = ~q0_h;
        if (sign_alt) sign_h = ~sign_h;
    endtask

    // Issues one operation from IDLE and follows it to done_h (bounded).
    task automatic run_op(input bit div, input bit dz, input bit ab,
                          output int done_at, output int busy_n,
                          output int load_dq, output int dvz_at_done);
        start_h = 1'b1; op_div_h = div; dvz_in_h = dz; abort_h = ab;
        tick();
        start_h = 1'b0; op_div_h = 1'b0; dvz_in_h = 1'b0; abort_h = 1'b0;
        done_at = -1; busy_n = 0; load_dq = -1; dvz_at_done = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk_h);
            if (n == 1) load_dq = int'(dq_h);
            if (busy_h) busy_n++;
            if (done_h) begin
                done_at = n;
                dvz_at_done = int'(dvz_h);
                break;
            end
            tick();
        end
        if (done_at < 0) check("done_timeout", 0, 1);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d_at, b_n, l_dq, dz_d;
        int dones[$];
        int loads[$];
        bit found;

        tick(); tick();
        @(negedge clk_h);
        check("rst_busy", int'(busy_h), 0);
        check("rst_dq", int'(dq_h), 0);
        check("rst_mux", int'(mux_h), 4);
        check("rst_inh", int'(dreg_inh_l), 0);
        tick();
        reset_h = 1'b0;
        tick();

        // multiply, q0 alternating
        q0_alt = 1'b1;
        run_op(1'b0, 1'b0, 1'b0, d_at, b_n, l_dq, dz_d);
        check("mul_done_cycle", d_at, 34);
        check("mul_busy_cycles", b_n, 33);
        check("mul_load_dq", l_dq, 2);
        q0_alt = 1'b0;

        // divide, sign held 1 (fixup adds back)
        sign_h = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, d_at, b_n, l_dq, dz_d);
        check("div_done_cycle", d_at, 35);
        check("div_busy_cycles", b_n, 34);
        check("div_dvz", dz_d, 0);

        // divide, sign alternating
        sign_alt = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, d_at, b_n, l_dq, dz_d);
        check("div_alt_done_cycle", d_at, 35);
        sign_alt = 1'b0;
        sign_h = 1'b0;

        // divide by zero, then a normal start clears the flag
        run_op(1'b1, 1'b1, 1'b0, d_at, b_n, l_dq, dz_d);
        check("dvz_done_cycle", d_at, 1);
        check("dvz_flag", dz_d, 1);
        check("dvz_no_busy", b_n, 0);
        run_op(1'b0, 1'b0, 1'b0, d_at, b_n, l_dq, dz_d);
        check("dvz_cleared", dz_d, 0);

        // abort at step 5
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_h);
            if (busy_h && step_h == 4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reach_step4", int'(found), 1);
        tick();
        abort_h = 1'b1;
        @(negedge clk_h);
        check("abort_step", int'(step_h), 5);
        tick();
        abort_h = 1'b0;
        @(negedge clk_h);
        check("abort_busy", int'(busy_h), 0);
        check("abort_done", int'(done_h), 0);
        check("abort_mux", int'(mux_h), 4);
        // start together with abort in IDLE is accepted
        run_op(1'b0, 1'b0, 1'b1, d_at, b_n, l_dq, dz_d);
        check("start_abort_done", d_at, 34);

        // back-to-back multiplies with start held high
        start_h = 1'b1;
        tick();
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk_h);
            if (dmove_h) loads.push_back(n);
            if (done_h) dones.push_back(n);
            if (dones.size() == 2) break;
            tick();
        end
        tick();
        start_h = 1'b0;
        check("b2b_done_count", dones.size(), 2);
        check("b2b_load_count", loads.size(), 2);
        if (dones.size() == 2) begin
            check("b2b_done1", dones[0], 34);
            check("b2b_done2", dones[1], 69);
        end
        if (loads.size() == 2) begin
            check("b2b_load1", loads[0], 1);
            check("b2b_load2", loads[1], 36);
        end
        tick(); tick();

        // reset mid-operation
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        tick(); tick(); tick();
        reset_h = 1'b1;
        #1;
        check("midrst_busy", int'(busy_h), 0);
        check("midrst_step", int'(step_h), 0);
        check("midrst_mux", int'(mux_h), 4);
        check("midrst_inh", int'(dreg_inh_l), 0);
        tick();
        reset_h = 1'b0;
        for (int n = 0; n < 40; n++) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
